// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-entry output buffer.
// rx_valid rises ~2+DIV/2+9*DIV clocks after the start edge; a byte finishing while the buffer is full is dropped (overrun).
module uart_rx #(
   parameter int CLK_MHZ = 12,
   parameter int BAUD    = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int DIV = CLK_MHZ * 1000000 / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            rx_s_q, rx_s_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;

   always_comb begin
      state_d     = state_q;
      sync1_d     = rx;
      rx_s_d      = sync1_q;
      cnt_d       = cnt_q + CW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q && !rx_ready;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (cnt_q == HALF_M1) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end else begin
                  state_d = S_IDLE;
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         S_BREAK: begin
            // Holding here keeps a long break from reporting more than one error.
            cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: DIV=8 instance for directed and random frames, default-rate instance for one frame.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx8, rdy8, rx104, rdy104;
   logic [7:0] data8, data104;
   logic       vld8, vld104, fe8, fe104, ov8, ov104;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int cyc    = 0;
   int start_cyc;

   // Monitor state
   logic [7:0] got8[$];
   logic [7:0] got104[$];
   int vcyc8, fecnt8, ovcnt8, both8, rise8;
   int vcyc104, fecnt104, ovcnt104, rise104;
   logic prev8 = 1'b0, prev104 = 1'b0;

   // Reference model for random frames
   logic [7:0] exp_q[$];
   int exp_fe;

   uart_rx #(.CLK_MHZ(1), .BAUD(125000)) dut (
      .clk(clk), .rst(rst), .rx(rx8), .rx_data(data8), .rx_valid(vld8),
      .rx_ready(rdy8), .frame_err(fe8), .overrun(ov8));

   uart_rx dut_def (
      .clk(clk), .rst(rst), .rx(rx104), .rx_data(data104), .rx_valid(vld104),
      .rx_ready(rdy104), .frame_err(fe104), .overrun(ov104));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vld8 && rdy8) got8.push_back(data8);
      if (vld8) vcyc8++;
      if (vld8 && !prev8) rise8 = cyc;
      if (fe8) fecnt8++;
      if (ov8) ovcnt8++;
      if (fe8 && ov8) both8++;
      prev8 = vld8;
      if (vld104 && rdy104) got104.push_back(data104);
      if (vld104) vcyc104++;
      if (vld104 && !prev104) rise104 = cyc;
      if (fe104) fecnt104++;
      if (ov104) ovcnt104++;
      prev104 = vld104;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      got8.delete();
      got104.delete();
      vcyc8 = 0; fecnt8 = 0; ovcnt8 = 0; rise8 = -1;
      vcyc104 = 0; fecnt104 = 0; ovcnt104 = 0; rise104 = -1;
   endtask

   task automatic line8(input logic v, input int n);
      rx8 = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame8(input logic [7:0] b, input logic stop_bit);
      start_cyc = cyc;
      line8(1'b0, 8);
      for (int i = 0; i < 8; i++) line8(b[i], 8);
      line8(stop_bit, 8);
   endtask

   task automatic line104(input logic v);
      rx104 = v;
      repeat (104) @(posedge clk);
      #1;
   endtask

   initial begin
      both8 = 0;
      clr();
      rst = 1'b1; rx8 = 1'b1; rx104 = 1'b1; rdy8 = 1'b0; rdy104 = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and idle line
      chk("rst_valid", vld8, 0);
      chk("rst_data", data8, 0);
      chk("rst_fe", fe8, 0);
      chk("rst_ov", ov8, 0);
      line8(1'b1, 200);
      chk("idle_valid_cycles", vcyc8, 0);
      chk("idle_fe", fecnt8, 0);
      chk("idle_ov", ovcnt8, 0);
      chk("idle_data", data8, 0);

      // 0xA5 with consumer ready: single-cycle pulse, latency window
      clr();
      rdy8 = 1'b1;
      frame8(8'hA5, 1'b1);
      line8(1'b1, 16);
      chk("a5_count", got8.size(), 1);
      chk("a5_byte", (got8.size() > 0) ? got8[0] : 8'hxx, 8'hA5);
      chk("a5_pulse_len", vcyc8, 1);
      chk("a5_latency", (rise8 - start_cyc >= 78) && (rise8 - start_cyc <= 80), 1);

      // Overrun: buffer held full across two frames
      clr();
      rdy8 = 1'b0;
      frame8(8'h3C, 1'b1);
      chk("ovr_first_valid", vld8, 1);
      chk("ovr_first_data", data8, 8'h3C);
      frame8(8'hC3, 1'b1);
      line8(1'b1, 4);
      chk("ovr_pulses", ovcnt8, 1);
      chk("ovr_data_kept", data8, 8'h3C);
      chk("ovr_still_valid", vld8, 1);
      rdy8 = 1'b1;
      @(posedge clk);
      #1 rdy8 = 1'b0;
      chk("ovr_drain_valid", vld8, 0);
      chk("ovr_drain_byte", (got8.size() == 1) ? got8[0] : 8'hxx, 8'h3C);

      // Framing error followed by a held break
      clr();
      rdy8 = 1'b1;
      frame8(8'h55, 1'b0);
      line8(1'b0, 40);
      line8(1'b1, 16);
      chk("fe_pulses", fecnt8, 1);
      chk("fe_no_valid", vcyc8, 0);
      frame8(8'h01, 1'b1);
      line8(1'b1, 16);
      chk("fe_recover", (got8.size() == 1) ? got8[0] : 8'hxx, 8'h01);

      // Short glitch then a valid frame
      clr();
      line8(1'b0, 3);
      line8(1'b1, 16);
      chk("glitch_no_valid", vcyc8, 0);
      chk("glitch_no_fe", fecnt8, 0);
      frame8(8'hFF, 1'b1);
      line8(1'b1, 16);
      chk("glitch_then_ff", (got8.size() == 1) ? got8[0] : 8'hxx, 8'hFF);

      // Reset in the middle of 0x81 after bit 3
      clr();
      line8(1'b0, 8);
      for (int i = 0; i < 4; i++) line8(((8'h81 >> i) & 8'h01) != 0, 8);
      rst = 1'b1;
      rx8 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      line8(1'b1, 40);
      chk("midrst_no_valid", vcyc8, 0);
      chk("midrst_no_fe", fecnt8, 0);
      frame8(8'h7E, 1'b1);
      line8(1'b1, 16);
      chk("midrst_then_7e", (got8.size() == 1) ? got8[0] : 8'hxx, 8'h7E);

      // Random frames against the line-level model
      clr();
      exp_q.delete();
      exp_fe = 0;
      for (int f = 0; f < 24; f++) begin
         logic [7:0] b;
         logic       good;
         int         acc;
         b    = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         frame8(b, good);
         // Model reconstructs the byte from the transmitted LSB-first bit sequence.
         acc = 0;
         for (int i = 0; i < 8; i++) acc += ((int'(b) >> i) & 1) * (1 << i);
         if (good) exp_q.push_back(8'(acc));
         else exp_fe++;
         line8(1'b1, 8 * (good ? $urandom_range(0, 2) : $urandom_range(1, 2)));
      end
      line8(1'b1, 24);
      chk("rand_count", got8.size(), exp_q.size());
      chk("rand_fe", fecnt8, exp_fe);
      chk("rand_ov", ovcnt8, 0);
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("rand_byte%0d", i), (i < got8.size()) ? got8[i] : 8'hxx, exp_q[i]);

      // Default rate (DIV=104)
      clr();
      rdy104 = 1'b1;
      start_cyc = cyc;
      line104(1'b0);
      for (int i = 0; i < 8; i++) line104(((8'hA5 >> i) & 8'h01) != 0);
      line104(1'b1);
      line104(1'b1);
      chk("def_count", got104.size(), 1);
      chk("def_byte", (got104.size() > 0) ? got104[0] : 8'hxx, 8'hA5);
      chk("def_latency", (rise104 - start_cyc >= 990) && (rise104 - start_cyc <= 992), 1);
      chk("def_fe", fecnt104, 0);

      chk("never_fe_and_ov", both8, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
